// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the SRAM request bridge: default geometry of the
// attached SRAM macro, the statistics counter width and the bridge FSM states.
// No ports (package).
// -----------------------------------------------------------------------------
package sram_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_WMASKS = 4;
    localparam int CNT_WIDTH      = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   synchronous active-low reset, clears the count
//   inc      in   increment request for this edge
//   count    out  current count, WIDTH bits
// -----------------------------------------------------------------------------
module sat_counter
    import sram_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sram_req_bridge.sv
// -----------------------------------------------------------------------------
// sram_req_bridge
// Converts a valid/ready request stream into single-port SRAM macro cycles and
// returns one response per request (read data, or zero for writes). Only one
// request is ever in flight, giving at most one request every two cycles.
// Ports:
//   clock, reset_n                 clock and synchronous active-low reset
//   req_valid/req_ready            request handshake
//   req_we/addr/wdata/wmask        request payload (wmask bit i -> byte i)
//   resp_valid/resp_ready          response handshake
//   resp_we, resp_rdata            response payload (rdata is 0 for writes)
//   sram_csb/web/wmask/addr/din    SRAM macro inputs (csb, web active-low)
//   sram_dout                      SRAM macro read data
//   rd_count, wr_count             saturating counts of accepted reads/writes
// -----------------------------------------------------------------------------
module sram_req_bridge
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_WMASKS = DEF_NUM_WMASKS  // DATA_WIDTH must be 8*NUM_WMASKS
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_we,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic [NUM_WMASKS-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  wr_count
);

    state_t state;
    state_t state_next;
    logic   fire;
    logic   resp_fire;
    logic   we_q;       // direction of the request currently in flight

    assign resp_fire = resp_valid && resp_ready;

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: every variable written in an always_comb block receives a default
    // first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (fire) state_next = ST_ACCESS;
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP: begin
                if (resp_fire) state_next = fire ? ST_ACCESS : ST_IDLE;
            end
            default:   state_next = ST_IDLE;
        endcase
    end

    // Output logic. Acceptance depends only on state and resp_ready, never on
    // req_valid; the SRAM is driven straight from the request in the fire cycle
    // so the macro samples it on the same edge that accepts the request.
    always_comb begin
        req_ready  = reset_n && ((state == ST_IDLE) || ((state == ST_RESP) && resp_ready));
        fire       = req_valid && req_ready;
        sram_csb   = 1'b1;
        sram_web   = 1'b1;
        sram_wmask = '0;
        sram_addr  = '0;
        sram_din   = '0;
        if (fire) begin
            sram_csb   = 1'b0;
            sram_web   = !req_we;
            sram_addr  = req_addr;
            sram_din   = req_wdata;
            sram_wmask = req_we ? req_wmask : '0;
        end
    end

    // Response register: loaded on the ACCESS edge, when the macro output for
    // the request sampled one edge earlier is valid, and held until consumed.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            we_q       <= 1'b0;
            resp_valid <= 1'b0;
            resp_we    <= 1'b0;
            resp_rdata <= '0;
        end else begin
            if (fire) begin
                we_q <= req_we;
            end
            if (state == ST_ACCESS) begin
                resp_valid <= 1'b1;
                resp_we    <= we_q;
                resp_rdata <= we_q ? '0 : sram_dout;
            end else if (resp_fire) begin
                resp_valid <= 1'b0;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_rd_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (fire && !req_we),
        .count   (rd_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_wr_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (fire && req_we),
        .count   (wr_count)
    );

endmodule

// File: tb/tb_sram_req_bridge.sv
// -----------------------------------------------------------------------------
// tb_sram_req_bridge
// Self-checking bench for sram_req_bridge. A behavioural SRAM macro answers the
// bridge; a word-array reference memory plus per-request expectations predict
// every response. A standalone sat_counter instance is run to its ceiling in a
// parallel process since a full-length top-level saturation run would be long.
// -----------------------------------------------------------------------------
module tb_sram_req_bridge;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NW = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [NW-1:0] req_wmask;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_we;
    logic [DW-1:0] resp_rdata;
    logic          sram_csb;
    logic          sram_web;
    logic [NW-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;
    logic [15:0]   rd_count;
    logic [15:0]   wr_count;

    logic          sat_rst_n;
    logic          sat_inc;
    logic [15:0]   sat_count;
    logic          sat_done = 1'b0;

    int total = 0;
    int bad   = 0;
    int exp_rd = 0;
    int exp_wr = 0;

    bit [DW-1:0] sram_mem [0:255];
    bit [DW-1:0] ref_mem  [0:255];

    always #5 clock = ~clock;

    sram_req_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NW)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_we    (resp_we),
        .resp_rdata (resp_rdata),
        .sram_csb   (sram_csb),
        .sram_web   (sram_web),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout),
        .rd_count   (rd_count),
        .wr_count   (wr_count)
    );

    sat_counter #(.WIDTH(16)) u_sat (
        .clock   (clock),
        .reset_n (sat_rst_n),
        .inc     (sat_inc),
        .count   (sat_count)
    );

    // SRAM macro model: samples its inputs on the edge, read data appears after
    // that edge; outside read cycles the output is scrambled.
    always @(posedge clock) begin
        if (!sram_csb && !sram_web) begin
            for (int b = 0; b < NW; b++)
                if (sram_wmask[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
            sram_dout <= $urandom;
        end else if (!sram_csb) begin
            sram_dout <= sram_mem[sram_addr];
        end else begin
            sram_dout <= $urandom;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_idle();
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_addr   = AW'($urandom);
        req_wdata  = $urandom;
        req_wmask  = NW'($urandom);
        resp_ready = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
            drive_idle();
            #1;
            check("idle_csb", sram_csb, 1);
            check("idle_wmask", sram_wmask, 0);
            check("idle_resp_valid", resp_valid, 0);
            check("idle_req_ready", req_ready, 1);
        end
    endtask

    // One complete request from an idle bridge: fire, access, response held for
    // 'stall' extra cycles, then consumed. Entered and left just after a negedge.
    task automatic run_txn(input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [NW-1:0] wmask,
                           input int stall, output logic [DW-1:0] got);
        logic [DW-1:0] exp_data;
        logic [DW-1:0] held;
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_wmask  = wmask;
        resp_ready = 1'b0;
        #1;
        check("fire_ready", req_ready, 1);
        check("fire_csb", sram_csb, 0);
        check("fire_web", sram_web, !we);
        check("fire_addr", sram_addr, addr);
        check("fire_din", sram_din, wdata);
        check("fire_wmask", sram_wmask, we ? wmask : 4'h0);
        if (we) begin
            for (int b = 0; b < NW; b++)
                if (wmask[b]) ref_mem[addr][b*8 +: 8] = wdata[b*8 +: 8];
            exp_data = '0;
            exp_wr   = (exp_wr < 65535) ? exp_wr + 1 : exp_wr;
        end else begin
            exp_data = ref_mem[addr];
            exp_rd   = (exp_rd < 65535) ? exp_rd + 1 : exp_rd;
        end
        @(posedge clock);
        @(negedge clock);
        drive_idle();
        req_valid = 1'b1;  // must be refused while the access is in progress
        #1;
        check("access_ready", req_ready, 0);
        check("access_csb", sram_csb, 1);
        check("access_wmask", sram_wmask, 0);
        check("access_addr", sram_addr, 0);
        check("access_resp_valid", resp_valid, 0);
        @(posedge clock);
        @(negedge clock);
        drive_idle();
        req_valid = 1'($urandom);
        #1;
        check("resp_valid", resp_valid, 1);
        check("resp_we", resp_we, we);
        check("resp_rdata", resp_rdata, exp_data);
        check("rd_count", rd_count, exp_rd);
        check("wr_count", wr_count, exp_wr);
        got  = resp_rdata;
        held = resp_rdata;
        for (int s = 0; s < stall; s++) begin
            @(posedge clock);
            @(negedge clock);
            req_valid = 1'($urandom);
            #1;
            check("hold_valid", resp_valid, 1);
            check("hold_rdata", resp_rdata, held);
            check("hold_we", resp_we, we);
            check("hold_ready", req_ready, 0);
            check("hold_csb", sram_csb, 1);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        #1;
        check("consume_ready", req_ready, 1);
        @(posedge clock);
        @(negedge clock);
        drive_idle();
        #1;
        check("consumed_valid", resp_valid, 0);
    endtask

    // Reads presented continuously with the consumer always ready: a request
    // must be accepted every other cycle, each while the previous response
    // is being consumed.
    task automatic back_to_back(input int n);
        logic [AW-1:0] last_addr = '0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 2 * n; i++) begin
            req_addr  = AW'($urandom_range(0, 15));
            req_wdata = $urandom;
            req_wmask = NW'($urandom);
            #1;
            if (i % 2 == 0) begin
                check("b2b_ready", req_ready, 1);
                check("b2b_csb", sram_csb, 0);
                check("b2b_wmask", sram_wmask, 0);
                if (i > 0) begin
                    check("b2b_valid", resp_valid, 1);
                    check("b2b_rdata", resp_rdata, ref_mem[last_addr]);
                end
                last_addr = req_addr;
                exp_rd    = (exp_rd < 65535) ? exp_rd + 1 : exp_rd;
            end else begin
                check("b2b_gap_ready", req_ready, 0);
                check("b2b_gap_valid", resp_valid, 0);
            end
            @(posedge clock);
            @(negedge clock);
        end
        req_valid = 1'b0;
        #1;
        check("b2b_last_valid", resp_valid, 1);
        check("b2b_last_rdata", resp_rdata, ref_mem[last_addr]);
        @(posedge clock);
        @(negedge clock);
        drive_idle();
        #1;
        check("b2b_drained", resp_valid, 0);
        check("b2b_rd_count", rd_count, exp_rd);
        check("b2b_wr_count", wr_count, exp_wr);
    endtask

    // Standalone saturation run of the counter sub-module.
    initial begin
        int sexp = 0;
        sat_rst_n = 1'b0;
        sat_inc   = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        check("sat_reset", sat_count, 0);
        sat_rst_n = 1'b1;
        for (int i = 0; i < 66000; i++) begin
            sat_inc = (i % 1000 == 7) ? 1'b0 : 1'b1;
            @(posedge clock);
            if (sat_inc) sexp = (sexp < 65535) ? sexp + 1 : sexp;
            @(negedge clock);
            if ((i % 4096 == 0) || (i % 1000 == 7) || (i > 65900))
                check("sat_count", sat_count, sexp);
        end
        check("sat_max", sat_count, 32'h0000_FFFF);
        sat_done = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] got;
        reset_n = 1'b0;
        drive_idle();
        req_valid = 1'b1;  // requests during reset must not reach the SRAM
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_csb", sram_csb, 1);
        check("rst_web", sram_web, 1);
        check("rst_wmask", sram_wmask, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_din", sram_din, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_we", resp_we, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_rd_count", rd_count, 0);
        check("rst_wr_count", wr_count, 0);
        drive_idle();
        reset_n = 1'b1;
        idle_cycles(2);

        // Full write then read back; partial-mask overwrite with a held response.
        run_txn(1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF, 0, got);
        check("dir_write_rdata", got, 0);
        run_txn(1'b0, 8'h10, 32'h0, 4'h0, 0, got);
        check("dir_read_full", got, 32'hDEAD_BEEF);
        run_txn(1'b1, 8'h10, 32'h1122_3344, 4'h5, 0, got);
        run_txn(1'b0, 8'h10, 32'h0, 4'hF, 5, got);
        check("dir_read_masked", got, 32'hDE22_BE44);
        // A write with no byte enables still produces a cycle and a response.
        run_txn(1'b1, 8'h10, 32'hFFFF_FFFF, 4'h0, 1, got);
        run_txn(1'b0, 8'h10, 32'h0, 4'h0, 0, got);
        check("dir_read_nomask", got, 32'hDE22_BE44);
        idle_cycles(3);

        for (int t = 0; t < 60; t++) begin
            run_txn(1'($urandom), AW'($urandom_range(0, 15)), $urandom,
                    NW'($urandom_range(0, 15)), $urandom_range(0, 3), got);
            idle_cycles($urandom_range(0, 2));
        end

        back_to_back(200);
        idle_cycles(1);

        // Reset while a read is in its access cycle: the response is dropped.
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 8'h10;
        resp_ready = 1'b1;
        #1;
        check("rst_mid_fire", req_ready, 1);
        @(posedge clock);
        @(negedge clock);
        drive_idle();
        reset_n = 1'b0;
        #1;
        check("rst_mid_ready", req_ready, 0);
        check("rst_mid_csb", sram_csb, 1);
        @(posedge clock);
        @(negedge clock);
        #1;
        check("rst_mid_resp_valid", resp_valid, 0);
        check("rst_mid_rd_count", rd_count, 0);
        check("rst_mid_wr_count", wr_count, 0);
        exp_rd = 0;
        exp_wr = 0;
        reset_n = 1'b1;
        idle_cycles(3);
        run_txn(1'b0, 8'h10, 32'h0, 4'h0, 0, got);
        check("post_rst_read", got, ref_mem[8'h10]);

        wait (sat_done);
        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_req_bridge.md
SRAM_REQ_BRIDGE -- requirements
Module: sram_req_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, SHALL set the word-address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the data width.
REQ-003 Parameter NUM_WMASKS, default 4, SHALL set the byte-enable width; DATA_WIDTH SHALL equal 8*NUM_WMASKS.
REQ-004 clock  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  SHALL be the synchronous, active-low reset.
REQ-006 req_valid  in  1  SHALL indicate a request is presented.
REQ-007 req_ready  out  1  SHALL indicate the bridge accepts the request this cycle.
REQ-008 req_we  in  1  SHALL mean write when 1, read when 0.
REQ-009 req_addr  in  ADDR_WIDTH  SHALL carry the word address.
REQ-010 req_wdata  in  DATA_WIDTH  SHALL carry the write data.
REQ-011 req_wmask  in  NUM_WMASKS  SHALL carry the byte enables (bit i -> byte i).
REQ-012 resp_valid  out  1  SHALL indicate a response is held.
REQ-013 resp_ready  in  1  SHALL indicate the consumer takes the response.
REQ-014 resp_we  out  1  SHALL echo req_we of the responded request.
REQ-015 resp_rdata  out  DATA_WIDTH  SHALL carry the read data; 0 for writes.
REQ-016 sram_csb  out  1  SHALL be the active-low SRAM chip select.
REQ-017 sram_web  out  1  SHALL be the active-low SRAM write enable.
REQ-018 sram_wmask  out  NUM_WMASKS  SHALL be the SRAM byte enables.
REQ-019 sram_addr  out  ADDR_WIDTH  SHALL be the SRAM address.
REQ-020 sram_din  out  DATA_WIDTH  SHALL be the SRAM write data.
REQ-021 sram_dout  in  DATA_WIDTH  SHALL be the SRAM read data, stable by the second rising edge after its inputs are sampled.
REQ-022 rd_count, wr_count  out  16 each  SHALL count accepted reads and writes.

Function
REQ-023 Handshake: request accepted ("fire") on a rising edge where req_valid && req_ready; resp consumed where resp_valid && resp_ready.
REQ-024 FSM states IDLE, ACCESS, RESP; IDLE fire->ACCESS; ACCESS->RESP unconditionally; RESP: resp consumed with fire->ACCESS, resp consumed without fire->IDLE, else hold RESP.
REQ-025 req_ready = reset_n && (IDLE || (RESP && resp_ready)); combinational, no dependency on req_valid.
REQ-026 SRAM drive is combinational in the fire cycle: sram_csb = !fire, sram_web = !req_we, sram_addr/sram_din pass-through, sram_wmask = req_wmask for writes, 0 for reads.
REQ-027 When not firing: sram_csb=1, sram_web=1, sram_wmask=0, sram_addr=0, sram_din=0.
REQ-028 On the ACCESS->RESP edge: resp_rdata <= sram_dout for reads, 0 for writes; resp_we <= stored req_we; resp_valid <= 1.
REQ-029 Latency: fire at edge E -> resp_valid high from edge E+2; peak throughput one request per 2 cycles.
REQ-030 resp_we/resp_rdata SHALL be stable while resp_valid && !resp_ready.
REQ-031 Writes with req_wmask=0 SHALL still perform the SRAM cycle and return a response.
REQ-032 Counters: increment on fire by type; saturate at 0xFFFF, no wrap.
REQ-033 At most one request in flight; no request accepted in ACCESS.

Reset
REQ-034 While reset_n=0 at an edge: state<=IDLE, resp_valid<=0, resp_we<=0, resp_rdata<=0, counters<=0.
REQ-035 While reset_n=0: req_ready=0, so sram_csb=1 and all SRAM outputs at REQ-027 idle values.
REQ-036 Reset in ACCESS or RESP SHALL drop the in-flight response; a write already sampled by the SRAM may complete.

Structure
REQ-037 Shared package sram_pkg SHALL hold default ADDR_WIDTH/DATA_WIDTH/NUM_WMASKS constants and the FSM state enum.
REQ-038 Saturating 16-bit counter SHALL be sub-module sat_counter, instantiated twice.

Verification
REQ-039 Write addr 0x10 data 0xDEADBEEF mask 0xF, then read 0x10 -> write resp (resp_we=1, rdata 0), read resp_rdata 0xDEADBEEF at edge fire+2.
REQ-040 Write 0x10 data 0x11223344 mask 0x5 over 0xDEADBEEF, read 0x10 -> 0xDE22BE44.
REQ-041 Read with resp_ready=0 for 5 cycles -> resp_valid held, rdata stable, req_ready=0; resp_ready=1 with req_valid=1 -> next request fires same edge.
REQ-042 Assert reset_n=0 in ACCESS of a read -> resp_valid 0 after edge, sram_csb=1, counters 0, no response produced.
REQ-043 Back-to-back 70000 reads with resp_ready=1 -> one fire per 2 cycles, rd_count saturates at 0xFFFF, wr_count 0.
REQ-044 Idle cycles with req_valid=0 -> sram_csb=1, sram_wmask=0, resp_valid=0.
